// File: rtl/seq_player.sv
// seq_player: playback side of the 16-step beat store.
// Walks the 16 pitch slots at a programmable tempo and presents one pitch per
// step with a 50% gate plus step/bar strobes for the downstream tone generator.
// Optional build macro SEQ_PLAYER_LOOP_LEN_EN adds a loop_last input that
// shortens the loop so it wraps after step loop_last instead of step 15.
module seq_player #(
    parameter int PERIOD_W  = 24,
    parameter int NUM_STEPS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          beats [0:NUM_STEPS-1],
    input  logic                play,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] period,
`ifdef SEQ_PLAYER_LOOP_LEN_EN
    input  logic [3:0]          loop_last,
`endif
    output logic [3:0]          step_index,
    output logic [2:0]          pitch_out,
    output logic                gate,
    output logic                step_strobe,
    output logic                bar_strobe,
    output logic                playing
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PLAY = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [3:0]          step_q, step_d;
    logic [2:0]          pitch_q, pitch_d;
    logic                gate_q, gate_d;
    logic                stepStrobe_q, stepStrobe_d;
    logic                barStrobe_q, barStrobe_d;

    logic [PERIOD_W-1:0] periodClamped;
    logic [PERIOD_W-1:0] lastCnt;
    logic [PERIOD_W-1:0] halfCnt;
    logic [3:0]          nextStep;

    // A step shorter than two cycles would leave no room for the gate to fall,
    // so tiny tempo periods are raised to two.
    assign periodClamped = (period < PERIOD_W'(2)) ? PERIOD_W'(2) : period;
    assign lastCnt       = period_q - PERIOD_W'(1);
    assign halfCnt       = (period_q >> 1) - PERIOD_W'(1);

`ifdef SEQ_PLAYER_LOOP_LEN_EN
    // Wrap after loop_last; a loop_last that was lowered below the current
    // step mid-bar also sends us straight back to step 0.
    assign nextStep = (step_q >= loop_last) ? 4'd0 : step_q + 4'd1;
`else
    // Full 16-step loop; the 4-bit add wraps 15 back to 0 on its own.
    assign nextStep = step_q + 4'd1;
`endif

    // Next-state logic: start on play, abort on stop, otherwise count through
    // the step and latch the next slot at each boundary.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        step_d       = step_q;
        pitch_d      = pitch_q;
        gate_d       = gate_q;
        stepStrobe_d = 1'b0;
        barStrobe_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (play && !stop) begin
                    state_d      = PLAY;
                    cnt_d        = '0;
                    period_d     = periodClamped;
                    step_d       = 4'd0;
                    pitch_d      = beats[0];
                    gate_d       = (beats[0] != 3'd0);
                    stepStrobe_d = 1'b1;
                    barStrobe_d  = 1'b1;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    step_d   = 4'd0;
                    pitch_d  = 3'd0;
                    gate_d   = 1'b0;
                end else if (cnt_q == lastCnt) begin
                    cnt_d        = '0;
                    period_d     = periodClamped;
                    step_d       = nextStep;
                    pitch_d      = beats[nextStep];
                    gate_d       = (beats[nextStep] != 3'd0);
                    stepStrobe_d = 1'b1;
                    barStrobe_d  = (nextStep == 4'd0);
                end else begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                    if (cnt_q == halfCnt) begin
                        gate_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset drops everything to silent IDLE on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            period_q     <= PERIOD_W'(2);
            step_q       <= 4'd0;
            pitch_q      <= 3'd0;
            gate_q       <= 1'b0;
            stepStrobe_q <= 1'b0;
            barStrobe_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            step_q       <= step_d;
            pitch_q      <= pitch_d;
            gate_q       <= gate_d;
            stepStrobe_q <= stepStrobe_d;
            barStrobe_q  <= barStrobe_d;
        end
    end

    assign step_index  = step_q;
    assign pitch_out   = pitch_q;
    assign gate        = gate_q;
    assign step_strobe = stepStrobe_q;
    assign bar_strobe  = barStrobe_q;
    assign playing     = (state_q == PLAY);

endmodule

// File: tb/tb_seq_player.sv
// tb_seq_player: randomized bench for seq_player against a timeline model
// (current step, cycles elapsed in it, step length), plus directed scenarios
// with hand-computed expectations. Honours SEQ_PLAYER_LOOP_LEN_EN.
module tb_seq_player;

    localparam int PERIOD_W = 24;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                play = 1'b0;
    logic                stop = 1'b0;
    logic [PERIOD_W-1:0] period = 24'd10;
    logic [2:0]          beats [0:15];
    logic [3:0]          loopLast = 4'd15;

    logic [3:0] step_index;
    logic [2:0] pitch_out;
    logic       gate;
    logic       step_strobe;
    logic       bar_strobe;
    logic       playing;

    int checkCount = 0;
    int passCount  = 0;

    seq_player #(.PERIOD_W(PERIOD_W), .NUM_STEPS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .beats       (beats),
        .play        (play),
        .stop        (stop),
        .period      (period),
`ifdef SEQ_PLAYER_LOOP_LEN_EN
        .loop_last   (loopLast),
`endif
        .step_index  (step_index),
        .pitch_out   (pitch_out),
        .gate        (gate),
        .step_strobe (step_strobe),
        .bar_strobe  (bar_strobe),
        .playing     (playing)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Behavioural model: where in the song are we, and how long is this step.
    int mPlaying = 0;
    int mStep = 0;
    int mPitch = 0;
    int mElapsed = 0;
    int mLen = 2;
    bit modelValid = 1'b0;

    function automatic int clampLen(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    function automatic int modelNext(input int s);
`ifdef SEQ_PLAYER_LOOP_LEN_EN
        return (s >= int'(loopLast)) ? 0 : s + 1;
`else
        return (s + 1) % 16;
`endif
    endfunction

    // Advance the model on every edge, then compare all outputs just after it.
    always @(posedge clk) begin
        if (rst) begin
            mPlaying = 0; mStep = 0; mPitch = 0; mElapsed = 0;
            modelValid = 1'b1;
        end else if (mPlaying == 0) begin
            if (play && !stop) begin
                mPlaying = 1; mStep = 0; mElapsed = 0;
                mLen = clampLen(int'(period));
                mPitch = int'(beats[0]);
            end
        end else if (stop) begin
            mPlaying = 0; mStep = 0; mPitch = 0; mElapsed = 0;
        end else if (mElapsed == mLen - 1) begin
            mElapsed = 0;
            mStep = modelNext(mStep);
            mLen = clampLen(int'(period));
            mPitch = int'(beats[mStep]);
        end else begin
            mElapsed++;
        end
        #1;
        if (modelValid) begin
            checkOutput("model_step_index", int'(step_index), (mPlaying != 0) ? mStep : 0);
            checkOutput("model_pitch_out", int'(pitch_out), (mPlaying != 0) ? mPitch : 0);
            checkOutput("model_gate", int'(gate),
                        ((mPlaying != 0) && (mPitch != 0) && (mElapsed < mLen / 2)) ? 1 : 0);
            checkOutput("model_step_strobe", int'(step_strobe),
                        ((mPlaying != 0) && (mElapsed == 0)) ? 1 : 0);
            checkOutput("model_bar_strobe", int'(bar_strobe),
                        ((mPlaying != 0) && (mElapsed == 0) && (mStep == 0)) ? 1 : 0);
            checkOutput("model_playing", int'(playing), mPlaying);
        end
    end

    // Wait for the strobe of a given step (target < 0 means any step), bounded.
    task automatic waitStep(input int target, input string name);
        int budget = 400;
        bit hit = 1'b0;
        do begin
            @(negedge clk);
            budget--;
            hit = step_strobe && ((target < 0) || (int'(step_index) == target));
        end while (!hit && budget > 0);
        if (!hit) begin
            checkCount++;
            $display("[TB] FAIL %s: timeout waiting for step %0d, got none, expected strobe", name, target);
        end
    endtask

    task automatic playPulse();
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
    endtask

    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            rst  = ($urandom_range(0, 499) == 0);
            play = ($urandom_range(0, 15) == 0);
            stop = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 2))
                    0: period = PERIOD_W'($urandom_range(0, 1));
                    1: period = PERIOD_W'($urandom_range(2, 3));
                    default: period = PERIOD_W'($urandom_range(4, 9));
                endcase
            end
            if ($urandom_range(0, 7) == 0) beats[$urandom_range(0, 15)] = 3'($urandom_range(0, 7));
`ifdef SEQ_PLAYER_LOOP_LEN_EN
            if ($urandom_range(0, 99) == 0) loopLast = 4'($urandom_range(0, 15));
`endif
            @(negedge clk);
        end
        rst = 1'b0; play = 1'b0; stop = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) beats[i] = (i < 7) ? 3'(i + 1) : 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_playing", int'(playing), 0);
        checkOutput("reset_gate", int'(gate), 0);

        // Start: first step appears one edge after play.
        playPulse();
        checkOutput("t1_step", int'(step_index), 0);
        checkOutput("t1_pitch", int'(pitch_out), 1);
        checkOutput("t1_gate", int'(gate), 1);
        checkOutput("t1_step_strobe", int'(step_strobe), 1);
        checkOutput("t1_bar_strobe", int'(bar_strobe), 1);
        checkOutput("t1_playing", int'(playing), 1);
        repeat (4) @(negedge clk);
        checkOutput("t1_gate_last_high", int'(gate), 1);
        @(negedge clk);
        checkOutput("t1_gate_low", int'(gate), 0);
        repeat (5) @(negedge clk);
        checkOutput("t1_step1", int'(step_index), 1);
        checkOutput("t1_pitch1", int'(pitch_out), 2);
        checkOutput("t1_strobe1", int'(step_strobe), 1);
        checkOutput("t1_bar1", int'(bar_strobe), 0);

        // Short steps, rest gate, and 15->0 wrap.
        period = 24'd4;
        waitStep(7, "t2_wait7");
        checkOutput("t2_rest_gate", int'(gate), 0);
        waitStep(0, "t2_wait0");
        checkOutput("t2_wrap_bar", int'(bar_strobe), 1);
        repeat (4) @(negedge clk);
        checkOutput("t2_step_after_wrap", int'(step_index), 1);
        checkOutput("t2_strobe_spacing", int'(step_strobe), 1);

        // beats edit mid-step only shows on the next pass.
        waitStep(3, "t3_wait3");
        checkOutput("t3_old_pitch", int'(pitch_out), 4);
        @(negedge clk);
        beats[3] = 3'd5;
        repeat (2) @(negedge clk);
        checkOutput("t3_pitch_held", int'(pitch_out), 4);
        waitStep(3, "t3_wait3_again");
        checkOutput("t3_new_pitch", int'(pitch_out), 5);

        // Tempo change mid-step, then clamp of period 0.
        period = 24'd10;
        waitStep(-1, "t4_sync_a");
        waitStep(-1, "t4_sync_b");
        repeat (3) @(negedge clk);
        period = 24'd6;
        repeat (6) @(negedge clk);
        checkOutput("t4_no_early_strobe", int'(step_strobe), 0);
        @(negedge clk);
        checkOutput("t4_long_step", int'(step_strobe), 1);
        repeat (6) @(negedge clk);
        checkOutput("t4_short_step", int'(step_strobe), 1);
        period = 24'd0;
        repeat (6) @(negedge clk);
        checkOutput("t4_last_six", int'(step_strobe), 1);
        @(negedge clk);
        checkOutput("t4_min_mid", int'(step_strobe), 0);
        @(negedge clk);
        checkOutput("t4_min_step", int'(step_strobe), 1);

        // stop+play together, restart, reset mid-step.
        period = 24'd4;
        waitStep(7, "t5_wait7");
        @(negedge clk);
        stop = 1'b1; play = 1'b1;
        @(negedge clk);
        stop = 1'b0; play = 1'b0;
        checkOutput("t5_stop_playing", int'(playing), 0);
        checkOutput("t5_stop_step", int'(step_index), 0);
        checkOutput("t5_stop_pitch", int'(pitch_out), 0);
        checkOutput("t5_stop_strobe", int'(step_strobe), 0);
        repeat (3) @(negedge clk);
        playPulse();
        checkOutput("t5_restart_step", int'(step_index), 0);
        checkOutput("t5_restart_bar", int'(bar_strobe), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t5_reset_playing", int'(playing), 0);
        checkOutput("t5_reset_gate", int'(gate), 0);

        // Loop length.
        period = 24'd4;
`ifdef SEQ_PLAYER_LOOP_LEN_EN
        loopLast = 4'd3;
        playPulse();
        waitStep(3, "t6_wait3");
        repeat (4) @(negedge clk);
        checkOutput("t6_loop_wrap_step", int'(step_index), 0);
        checkOutput("t6_loop_wrap_bar", int'(bar_strobe), 1);
        repeat (16) @(negedge clk);
        checkOutput("t6_loop_bar_again", int'(bar_strobe), 1);
`else
        playPulse();
        waitStep(15, "t6_wait15");
        repeat (4) @(negedge clk);
        checkOutput("t6_wrap_step", int'(step_index), 0);
        checkOutput("t6_wrap_bar", int'(bar_strobe), 1);
        repeat (64) @(negedge clk);
        checkOutput("t6_bar_again", int'(bar_strobe), 1);
`endif

        applyStimulus(4000);
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
